// File: rtl/skein_pkg.sv
// Shared Skein constants and types, used by the output register bank and the
// output word streamer.
//   WORD_WIDTH : width of one state word
//   NUM_WORDS  : words per state (state width = WORD_WIDTH*NUM_WORDS)
//   IDX_WIDTH  : width of a word index (2**IDX_WIDTH >= NUM_WORDS)
package skein_pkg;

  localparam int WORD_WIDTH = 64;
  localparam int NUM_WORDS  = 16;
  localparam int IDX_WIDTH  = 4;

  typedef logic [WORD_WIDTH-1:0] state_word_t;
  // Packed so that word k occupies bits [64k+63:64k] of the flat state.
  typedef state_word_t [NUM_WORDS-1:0] state_t;
  typedef logic [NUM_WORDS-1:0] word_mask_t;
  typedef logic [IDX_WIDTH-1:0] word_idx_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } stream_state_e;

endpackage

// File: rtl/output_word_streamer_if.sv
// Word stream handshake from the output word streamer to the result path.
//   word_valid_o : word_o/word_index_o/last_o are valid
//   word_ready_i : consumer accepts the current word when valid && ready
//   word_o       : current state word
//   word_index_o : index of the current word
//   last_o       : current word is the last one of the stream
// master = streamer side, slave = consumer side.
interface output_word_streamer_if;
  import skein_pkg::*;

  logic        word_valid_o;
  logic        word_ready_i;
  state_word_t word_o;
  word_idx_t   word_index_o;
  logic        last_o;

  modport master (
    output word_valid_o,
    output word_o,
    output word_index_o,
    output last_o,
    input  word_ready_i
  );

  modport slave (
    input  word_valid_o,
    input  word_o,
    input  word_index_o,
    input  last_o,
    output word_ready_i
  );

endinterface

// File: rtl/next_set_bit_finder.sv
// Combinational search over a word mask.
//   mask     : word mask to search
//   idx      : current word index
//   first    : 1 -> find the lowest set bit; 0 -> find the lowest set bit above idx
//   next_idx : index found (0 when nothing found)
//   found    : a qualifying set bit exists
//   is_last  : no set bit exists above next_idx
module next_set_bit_finder
  import skein_pkg::*;
(
  input  word_mask_t mask,
  input  word_idx_t  idx,
  input  logic       first,
  output word_idx_t  next_idx,
  output logic       found,
  output logic       is_last
);

  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    is_last  = 1'b1;
    // Scan downwards so the lowest qualifying bit is the one that sticks.
    for (int k = NUM_WORDS - 1; k >= 0; k--) begin
      if (mask[k] && (first || (k > int'(idx)))) begin
        next_idx = IDX_WIDTH'(k);
        found    = 1'b1;
      end
    end
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (found && mask[k] && (k > int'(next_idx))) begin
        is_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/output_word_streamer.sv
// Read side of the Skein output register bank. On start_i it snapshots the
// full state and the word mask, then streams the masked words in ascending
// index order, one per valid/ready handshake.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous reset, active-high
//   start_i     : snapshot state_i/word_mask_i and begin streaming (IDLE only)
//   state_i     : full state from the output register bank
//   word_mask_i : bit k set -> emit word k
//   busy_o      : high while words are being streamed
//   done_o      : one-cycle pulse after the final word, or after an empty-mask start
//   out_if      : word stream (valid/ready, word, index, last)
module output_word_streamer
  import skein_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  state_t                        state_i,
  input  word_mask_t                    word_mask_i,
  output logic                          busy_o,
  output logic                          done_o,
  output_word_streamer_if.master        out_if
);

  stream_state_e state;
  state_t        snap_p1;
  word_mask_t    mask_p1;

  word_mask_t    fnd_mask;
  logic          fnd_first;
  word_idx_t     fnd_next;
  logic          fnd_found;
  logic          fnd_last;

  // One finder serves both the start (lowest bit of the incoming mask) and
  // the advance (next bit above the current index of the captured mask).
  assign fnd_first = (state == S_IDLE);
  assign fnd_mask  = fnd_first ? word_mask_i : mask_p1;

  next_set_bit_finder u_finder (
    .mask     (fnd_mask),
    .idx      (out_if.word_index_o),
    .first    (fnd_first),
    .next_idx (fnd_next),
    .found    (fnd_found),
    .is_last  (fnd_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= S_IDLE;
      snap_p1             <= '0;
      mask_p1             <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      out_if.word_valid_o <= 1'b0;
      out_if.word_o       <= '0;
      out_if.word_index_o <= '0;
      out_if.last_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            snap_p1 <= state_i;
            mask_p1 <= word_mask_i;
            if (fnd_found) begin
              state               <= S_STREAM;
              busy_o              <= 1'b1;
              out_if.word_valid_o <= 1'b1;
              out_if.word_o       <= state_i[fnd_next];
              out_if.word_index_o <= fnd_next;
              out_if.last_o       <= fnd_last;
            end else begin
              state  <= S_FINISH;
              done_o <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          // Without ready everything holds, so a presented word never changes.
          if (out_if.word_ready_i) begin
            if (out_if.last_o) begin
              state               <= S_FINISH;
              busy_o              <= 1'b0;
              out_if.word_valid_o <= 1'b0;
              done_o              <= 1'b1;
            end else begin
              out_if.word_o       <= snap_p1[fnd_next];
              out_if.word_index_o <= fnd_next;
              out_if.last_o       <= fnd_last;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_word_streamer.sv
module tb_output_word_streamer;
  import skein_pkg::*;

  typedef struct packed {
    logic [3:0]  idx;
    logic [63:0] word;
    logic        last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  state_t     st;
  word_mask_t mask;
  logic       busy;
  logic       done;

  output_word_streamer_if sif ();

  output_word_streamer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .state_i     (st),
    .word_mask_i (mask),
    .busy_o      (busy),
    .done_o      (done),
    .out_if      (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: an accepted start turns into a list of the words the
  // stream must carry; each handshake removes the head; done follows the
  // last removal (or an empty list) and the cycle after done ignores start.
  exp_t q[$];
  logic m_done = 1'b0;
  int   top;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (q.size() > 0) begin
      if (sif.word_ready_i) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      top = -1;
      for (int k = 0; k < 16; k++) if (mask[k]) top = k;
      for (int k = 0; k < 16; k++)
        if (mask[k]) q.push_back('{idx: 4'(k), word: st[k], last: (k == top)});
      if (top < 0) m_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(sif.word_valid_o), 64'(q.size() > 0));
      check("busy", 64'(busy), 64'(q.size() > 0));
      check("done", 64'(done), 64'(m_done));
      if (q.size() > 0) begin
        check("word", sif.word_o, q[0].word);
        check("index", 64'(sif.word_index_o), 64'(q[0].idx));
        check("last", 64'(sif.last_o), 64'(q[0].last));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 16; k++) st[k] = 64'h1111_0000_0000_0000 + 64'(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(sif.word_valid_o), 64'd0);
    check({tag, "_word"}, sif.word_o, 64'd0);
    check({tag, "_index"}, 64'(sif.word_index_o), 64'd0);
    check({tag, "_last"}, 64'(sif.last_o), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mask = '0;
    st = '0;
    sif.word_ready_i = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick(1);

    // Full mask, ready held high
    load_ramp();
    mask = 16'hFFFF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("full_first_valid", 64'(sif.word_valid_o), 64'd1);
    check("full_first_index", 64'(sif.word_index_o), 64'd0);
    check("full_first_word", sif.word_o, 64'h1111_0000_0000_0000);
    tick(15);
    check("full_top_index", 64'(sif.word_index_o), 64'd15);
    check("full_top_last", 64'(sif.last_o), 64'd1);
    tick(1);
    check("full_done", 64'(done), 64'd1);
    tick(2);

    // Sparse mask 0,5,10,15
    mask = 16'h8421;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("sparse_len", 64'(q.size()), 64'd4);
    check("sparse_q1_idx", 64'(q[1].idx), 64'd5);
    check("sparse_q1_word", q[1].word, 64'h1111_0000_0000_0005);
    check("sparse_q3_last", 64'(q[3].last), 64'd1);
    tick(4);
    check("sparse_done", 64'(done), 64'd1);
    tick(2);

    // Empty mask
    mask = 16'h0000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("empty_done", 64'(done), 64'd1);
    check("empty_valid", 64'(sif.word_valid_o), 64'd0);
    check("empty_busy", 64'(busy), 64'd0);
    tick(2);

    // Backpressure at index 3 while state_i changes
    load_ramp();
    mask = 16'hFFFF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    sif.word_ready_i = 1'b0;
    for (int k = 0; k < 16; k++) st[k] = ~st[k];
    tick(5);
    check("bp_hold_word", sif.word_o, 64'h1111_0000_0000_0003);
    check("bp_hold_index", 64'(sif.word_index_o), 64'd3);
    sif.word_ready_i = 1'b1;
    tick(13);
    check("bp_done", 64'(done), 64'd1);
    tick(2);

    // Start while busy, and start during the done cycle
    for (int k = 0; k < 16; k++) st[k] = 64'hAAAA_0000_0000_0000 + 64'(3 * k);
    mask = 16'hFFFF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    load_ramp();
    mask = 16'h0001;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_ign_word", sif.word_o, 64'hAAAA_0000_0000_0009);
    tick(13);
    check("busy_ign_done", 64'(done), 64'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("finish_ign_done", 64'(done), 64'd0);
    check("finish_ign_valid", 64'(sif.word_valid_o), 64'd0);
    tick(2);

    // Reset after 7 of 16 words, then a fresh start
    load_ramp();
    mask = 16'hFFFF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    check("mid_index", 64'(sif.word_index_o), 64'd7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_outputs("midrst");
    tick(1);
    check("midrst_no_done", 64'(done), 64'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("fresh_index", 64'(sif.word_index_o), 64'd0);
    check("fresh_word", sif.word_o, 64'h1111_0000_0000_0000);
    tick(16);
    check("fresh_done", 64'(done), 64'd1);
    tick(2);

    // Start in the same cycle as reset: reset wins
    rst = 1'b1;
    start = 1'b1;
    tick(1);
    rst = 1'b0;
    start = 1'b0;
    check_reset_outputs("rst_start");
    tick(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
